// File: rtl/sevseg_display_arbiter.sv
// Two-requester round-robin arbiter for a shared 4-digit seven-segment driver.
// A granted word is latched, acknowledged and held on in0..in3 for at least DWELL cycles.
module sevseg_display_arbiter #(
    parameter int         DWELL     = 50_000_000,
    parameter int         DW        = 26,
    parameter logic [4:0] IDLE_CODE = 5'd17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [19:0] data0,
    input  logic        req1,
    input  logic [19:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [4:0]  in0,
    output logic [4:0]  in1,
    output logic [4:0]  in2,
    output logic [4:0]  in3,
    output logic [1:0]  owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          last;
    logic          grant0, grant1, release_disp;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        grant0       = 1'b0;
        grant1       = 1'b0;
        release_disp = 1'b0;
        case (state)
            // last == 1 means requester 1 was served last, so requester 0 wins a tie
            IDLE: begin
                if (req0 && (!req1 || last)) grant0 = 1'b1;
                else if (req1)               grant1 = 1'b1;
            end
            SHOW0: begin
                if (cnt != '0)   cnt_nxt = cnt - DW'(1);
                else if (req1)   grant1 = 1'b1;
                else if (req0)   grant0 = 1'b1;
                else             release_disp = 1'b1;
            end
            SHOW1: begin
                if (cnt != '0)   cnt_nxt = cnt - DW'(1);
                else if (req0)   grant0 = 1'b1;
                else if (req1)   grant1 = 1'b1;
                else             release_disp = 1'b1;
            end
            default: release_disp = 1'b1;
        endcase
        if (grant0) begin
            state_nxt = SHOW0;
            cnt_nxt   = DW'(DWELL - 1);
        end else if (grant1) begin
            state_nxt = SHOW1;
            cnt_nxt   = DW'(DWELL - 1);
        end else if (release_disp) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            in0   <= IDLE_CODE;
            in1   <= IDLE_CODE;
            in2   <= IDLE_CODE;
            in3   <= IDLE_CODE;
            owner <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack0  <= grant0;
            ack1  <= grant1;
            if (grant0) begin
                {in3, in2, in1, in0} <= data0;
                owner <= 2'b01;
                busy  <= 1'b1;
                last  <= 1'b0;
            end else if (grant1) begin
                {in3, in2, in1, in0} <= data1;
                owner <= 2'b10;
                busy  <= 1'b1;
                last  <= 1'b1;
            end else if (release_disp) begin
                {in3, in2, in1, in0} <= {4{IDLE_CODE}};
                owner <= 2'b00;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_display_arbiter.sv
// Directed bench for sevseg_display_arbiter with a time-based reference model
// compared every cycle, plus literal spot checks of key scenarios.
module tb_sevseg_display_arbiter;

    localparam int DWELL = 4;
    localparam logic [19:0] IDLE_WORD = {4{5'd17}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [19:0] data0 = '0, data1 = '0;
    logic        ack0, ack1, busy;
    logic [4:0]  in0, in1, in2, in3;
    logic [1:0]  owner;

    int checks = 0;
    int passes = 0;

    sevseg_display_arbiter #(.DWELL(DWELL), .DW(26), .IDLE_CODE(5'd17)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: owner 0 = none, 1 = req0, 2 = req1. Time kept as an
    // absolute edge count; a new decision is allowed once DWELL edges have passed.
    int          m_cyc, m_until, m_owner, m_last;
    logic [19:0] m_word;
    logic        m_ack0, m_ack1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_until = 0; m_owner = 0; m_last = 1;
            m_word = IDLE_WORD; m_ack0 = 0; m_ack1 = 0;
        end else begin
            int win;
            m_cyc++;
            m_ack0 = 0;
            m_ack1 = 0;
            if (m_owner == 0 || m_cyc >= m_until) begin
                win = 0;
                if (m_owner == 0) begin
                    if (req0 && req1) win = (m_last == 1) ? 1 : 2;
                    else if (req0)    win = 1;
                    else if (req1)    win = 2;
                end else begin
                    int other;
                    other = (m_owner == 1) ? 2 : 1;
                    if ((other == 1 && req0) || (other == 2 && req1)) win = other;
                    else if ((m_owner == 1 && req0) || (m_owner == 2 && req1)) win = m_owner;
                end
                m_owner = win;
                if (win == 0) m_word = IDLE_WORD;
                else begin
                    m_word  = (win == 1) ? data0 : data1;
                    m_until = m_cyc + DWELL;
                    m_last  = win - 1;
                    if (win == 1) m_ack0 = 1; else m_ack1 = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] e_owner;
            e_owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            check("model_digits", {in3, in2, in1, in0}, m_word);
            check("model_owner", owner, e_owner);
            check("model_busy", busy, (m_owner != 0));
            check("model_acks", {ack1, ack0}, {m_ack1, m_ack0});
            check("ack_exclusive", ack0 & ack1, 1'b0);
        end
    end

    // Wait (at negedges) for the given ack, bounded; a timeout counts as a failure.
    task automatic wait_ack(input int which, input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((which == 0 && ack0) || (which == 1 && ack1)) return;
        end
        checks++;
        $display("FAIL %s: timeout waiting for ack%0d, got none, expected one", name, which);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (owner == 2'b00) return;
        end
        checks++;
        $display("FAIL %s: timeout waiting for idle, owner 0x%0h expected 0", name, owner);
    endtask

    initial begin
        int order[$];
        // Reset and idle display
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_in0", in0, 5'd17);
        check("rst_in3", in3, 5'd17);
        check("rst_owner", owner, 2'b00);

        // Single request, held for exactly DWELL cycles
        data0 = {5'd1, 5'd2, 5'd3, 5'd4};
        req0 = 1'b1;
        wait_ack(0, "single_ack");
        req0 = 1'b0;
        check("single_digits", {in3, in2, in1, in0}, {5'd1, 5'd2, 5'd3, 5'd4});
        check("single_owner", owner, 2'b01);
        repeat (3) @(negedge clk);
        check("single_hold", {in3, in2, in1, in0}, {5'd1, 5'd2, 5'd3, 5'd4});
        check("single_ack_once", ack0, 1'b0);
        @(negedge clk);
        check("single_release", {in3, in0}, {5'd17, 5'd17});
        check("single_owner_idle", owner, 2'b00);

        // Tie, round-robin 0,1,0,1 at 4-cycle spacing
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        data0 = {4{5'd10}};
        data1 = {4{5'd11}};
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ack0) order.push_back(i * 10 + 0);
            if (ack1) order.push_back(i * 10 + 1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            check("rr_first", order[0], 0);
            check("rr_second", order[1], 41);
            check("rr_third", order[2], 80);
            check("rr_fourth", order[3], 121);
        end
        wait_idle("rr_idle");

        // Held re-grant with data changing mid-dwell
        data1 = 20'h0_0000;
        req1 = 1'b1;
        wait_ack(1, "regrant_ack");
        check("regrant_first", {in3, in2, in1, in0}, 20'h0_0000);
        @(negedge clk);
        data1 = {4{5'd16}};
        @(negedge clk);
        check("regrant_frozen", {in3, in2, in1, in0}, 20'h0_0000);
        repeat (2) @(negedge clk);
        check("regrant_ack2", ack1, 1'b1);
        check("regrant_digits", {in3, in2, in1, in0}, {4{5'd16}});
        req1 = 1'b0;
        wait_idle("regrant_idle");

        // Early drop of req0 then req1 arriving mid-dwell: no idle gap
        data0 = {5'd5, 5'd6, 5'd7, 5'd8};
        data1 = {5'd18, 5'd9, 5'd0, 5'd15};
        req0 = 1'b1;
        wait_ack(0, "drop_ack0");
        req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b1;
        repeat (2) @(negedge clk);
        check("drop_still_shown", {in3, in2, in1, in0}, {5'd5, 5'd6, 5'd7, 5'd8});
        @(negedge clk);
        check("drop_ack1", ack1, 1'b1);
        check("drop_owner", owner, 2'b10);
        check("drop_digits", {in3, in2, in1, in0}, {5'd18, 5'd9, 5'd0, 5'd15});

        // Reset mid-dwell of SHOW1, then tie restarts with requester 0
        req1 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_digits", {in3, in2, in1, in0}, IDLE_WORD);
        check("midrst_owner", owner, 2'b00);
        check("midrst_busy", busy, 1'b0);
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(0, "midrst_first");
        check("midrst_first_ack1", ack1, 1'b0);
        check("midrst_first_owner", owner, 2'b01);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
